// File: rtl/enemy_shot_scheduler.sv
// ============================================================================
// Module   : enemy_shot_scheduler
// Purpose  : Picks the next alive enemy round-robin, caps bullets in flight
//            and enforces a cooldown after each shot.
// Options  : define SHOT_BURST_EN for a second shot after a 4-cycle BGAP.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module enemy_shot_scheduler #(
  parameter int N_ENEMY      = 8,
  parameter int MAX_INFLIGHT = 3,
  parameter int COOLDOWN     = 40
) (
  input  logic                              pclk,
  input  logic                              rst,
  input  logic                              shoot_req,
  input  logic [N_ENEMY-1:0]                enemy_alive,
  input  logic                              bullet_done,
  output logic                              fire,
  output logic [$clog2(N_ENEMY)-1:0]        fire_id,
  output logic                              req_dropped,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              busy
);

  localparam int IDW = $clog2(N_ENEMY);
  localparam int IFW = $clog2(MAX_INFLIGHT + 1);
  localparam int CW  = $clog2(COOLDOWN + 4);

  localparam logic [IDW-1:0] c_last_idx     = IDW'(N_ENEMY - 1);
  localparam logic [IFW-1:0] c_max_inflight = IFW'(MAX_INFLIGHT);
  localparam logic [CW-1:0]  c_cool_load    = CW'(COOLDOWN - 1);
`ifdef SHOT_BURST_EN
  localparam logic [CW-1:0]  c_gap_load     = CW'(3);
`endif

`ifdef SHOT_BURST_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_FIRE = 3'd2,
    S_COOL = 3'd3,
    S_BGAP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_FIRE = 3'd2,
    S_COOL = 3'd3
  } state_t;
`endif

  state_t          r_state;
  state_t          w_next_state;

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_scan_cnt;
  logic [IDW-1:0]  r_fire_id;
  logic [IDW-1:0]  r_last_id;
  logic [CW-1:0]   r_cnt;
  logic [IFW-1:0]  r_inflight;
  logic            r_req_dropped;
`ifdef SHOT_BURST_EN
  logic            r_second;
  logic            w_load_gap;
`endif

  logic            w_start;
  logic            w_step;
  logic            w_hit;
  logic            w_drop;
  logic            w_load_cool;
  logic            w_cnt_dec;
  logic            w_room;
  logic            w_inc;
  logic            w_dec;
  logic [IDW-1:0]  w_ptr_inc;
  logic [IDW-1:0]  w_first_ptr;

  assign w_room      = (r_inflight < c_max_inflight);
  assign w_ptr_inc   = (r_ptr == c_last_idx) ? '0 : r_ptr + 1'b1;
  assign w_first_ptr = (r_last_id == c_last_idx) ? '0 : r_last_id + 1'b1;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_hit        = 1'b0;
    w_drop       = 1'b0;
    w_load_cool  = 1'b0;
    w_cnt_dec    = 1'b0;
`ifdef SHOT_BURST_EN
    w_load_gap   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (shoot_req) begin
          if (w_room) begin
            w_next_state = S_SCAN;
            w_start      = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (enemy_alive[r_ptr]) begin
          w_next_state = S_FIRE;
          w_hit        = 1'b1;
        end else if (r_scan_cnt == c_last_idx) begin
          // every shooter tested dead: give the request up
          w_next_state = S_IDLE;
          w_drop       = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      S_FIRE: begin
`ifdef SHOT_BURST_EN
        if (!r_second) begin
          w_next_state = S_BGAP;
          w_load_gap   = 1'b1;
        end else begin
          w_next_state = S_COOL;
          w_load_cool  = 1'b1;
        end
`else
        w_next_state = S_COOL;
        w_load_cool  = 1'b1;
`endif
      end
      S_COOL: begin
        if (r_cnt == '0) begin
          w_next_state = S_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
`ifdef SHOT_BURST_EN
      S_BGAP: begin
        if (r_cnt != '0) begin
          w_cnt_dec = 1'b1;
        end else if (w_room && enemy_alive[r_fire_id]) begin
          w_next_state = S_FIRE;
        end else begin
          w_next_state = S_COOL;
          w_load_cool  = 1'b1;
        end
      end
`endif
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_inc = (r_state == S_FIRE);
  assign w_dec = bullet_done && (r_inflight != '0);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_ptr         <= '0;
      r_scan_cnt    <= '0;
      r_fire_id     <= '0;
      r_last_id     <= c_last_idx;
      r_cnt         <= '0;
      r_inflight    <= '0;
      r_req_dropped <= 1'b0;
    end else begin
      r_req_dropped <= w_drop;

      if (w_start) begin
        r_ptr      <= w_first_ptr;
        r_scan_cnt <= '0;
      end else if (w_step) begin
        r_ptr      <= w_ptr_inc;
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end

      if (w_hit) begin
        r_fire_id <= r_ptr;
      end
      if (r_state == S_FIRE) begin
        r_last_id <= r_fire_id;
      end

      if (w_load_cool) begin
        r_cnt <= c_cool_load;
`ifdef SHOT_BURST_EN
      end else if (w_load_gap) begin
        r_cnt <= c_gap_load;
`endif
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // a launch and a retirement in the same cycle cancel out
      if (w_inc && !w_dec) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_inc && w_dec) begin
        r_inflight <= r_inflight - 1'b1;
      end
    end
  end

`ifdef SHOT_BURST_EN
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_second <= 1'b0;
    end else if (w_hit) begin
      r_second <= 1'b0;
    end else if (r_state == S_FIRE) begin
      r_second <= 1'b1;
    end
  end
`endif

  assign fire        = (r_state == S_FIRE);
  assign fire_id     = r_fire_id;
  assign req_dropped = r_req_dropped;
  assign inflight    = r_inflight;
  assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_enemy_shot_scheduler.sv
// ============================================================================
// Module   : tb_enemy_shot_scheduler
// Purpose  : Directed plus random stimulus against a shot-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_enemy_shot_scheduler;

  localparam int N    = 8;
  localparam int MAXF = 3;
  localparam int COOL = 40;

  logic         pclk = 1'b0;
  logic         rst;
  logic         shoot_req;
  logic         bullet_done;
  logic [N-1:0] alive;
  logic         fire;
  logic [2:0]   fire_id;
  logic         req_dropped;
  logic [1:0]   inflight;
  logic         busy;

  enemy_shot_scheduler #(
    .N_ENEMY      (N),
    .MAX_INFLIGHT (MAXF),
    .COOLDOWN     (COOL)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .shoot_req   (shoot_req),
    .enemy_alive (alive),
    .bullet_done (bullet_done),
    .fire        (fire),
    .fire_id     (fire_id),
    .req_dropped (req_dropped),
    .inflight    (inflight),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  int cyc;
  int n_checks;
  int n_fail;
  int t;

  // schedule model: absolute cycle numbers of upcoming events
  int m_fire_cyc;
  int m_fire_id;
  int m_drop_cyc;
  int m_busy_end;
  int m_gap_dec;
  int m_inflight;
  int m_last_id;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fire_cyc = -1;
    m_fire_id  = 0;
    m_drop_cyc = -1;
    m_busy_end = cyc;
    m_gap_dec  = -1;
    m_inflight = 0;
    m_last_id  = N - 1;
  endtask

  // Check outputs of the current cycle, drive inputs, advance model and clock.
  task automatic step(input logic sreq, input logic bdone);
    logic exp_fire;
    logic exp_busy;
    logic found;
    int   k;
    int   id;
    exp_fire = (cyc == m_fire_cyc);
    exp_busy = (cyc < m_busy_end);
    check_eq("fire", fire, exp_fire);
    check_eq("busy", busy, exp_busy);
    check_eq("req_dropped", req_dropped, cyc == m_drop_cyc);
    check_eq("inflight", inflight, m_inflight);
    if (exp_fire) check_eq("fire_id", fire_id, m_fire_id);

    shoot_req   = sreq;
    bullet_done = bdone;

    if (!exp_busy && sreq) begin
      if (m_inflight < MAXF) begin
        found = 1'b0;
        k     = 0;
        id    = 0;
        for (int j = 0; j < N; j++) begin
          if (!found && alive[(m_last_id + 1 + j) % N]) begin
            found = 1'b1;
            k     = j;
            id    = (m_last_id + 1 + j) % N;
          end
        end
        if (found) begin
          m_fire_cyc = cyc + 2 + k;
          m_fire_id  = id;
`ifdef SHOT_BURST_EN
          m_gap_dec  = m_fire_cyc + 4;
          m_busy_end = m_fire_cyc + 6 + COOL;
`else
          m_busy_end = m_fire_cyc + 1 + COOL;
`endif
        end else begin
          m_drop_cyc = cyc + 1 + N;
          m_busy_end = cyc + 1 + N;
        end
      end else begin
        m_drop_cyc = cyc + 1;
      end
    end

`ifdef SHOT_BURST_EN
    if (cyc == m_gap_dec) begin
      m_gap_dec = -1;
      if (m_inflight < MAXF && alive[m_fire_id]) begin
        m_fire_cyc = cyc + 1;
        m_busy_end = cyc + 2 + COOL;
      end else begin
        m_busy_end = cyc + 1 + COOL;
      end
    end
`endif

    if (exp_fire) m_last_id = m_fire_id;
    if (exp_fire && !(bdone && m_inflight > 0)) m_inflight++;
    else if (!exp_fire && bdone && m_inflight > 0) m_inflight--;

    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    shoot_req   = 1'b0;
    bullet_done = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_fire", fire, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_inflight", inflight, 0);
    check_eq("rst_fire_id", fire_id, 0);
    check_eq("rst_req_dropped", req_dropped, 0);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    alive    = '1;
    do_reset();

    // single shot from reset, all alive
    t = cyc;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("first_fire", fire, 1);
    check_eq("first_id", fire_id, 0);
    step(1'b0, 1'b0);
    check_eq("first_inflight", inflight, 1);
`ifndef SHOT_BURST_EN
    run(COOL - 1);
    check_eq("cool_last_busy", busy, 1);
    step(1'b0, 1'b0);
    check_eq("cool_end_idle", busy, 0);
`endif
    run(10);

    // fill to the in-flight cap, then one more request is dropped
    step(1'b1, 1'b0); run(50);
    step(1'b1, 1'b0); run(50);
    step(1'b1, 1'b0);
    check_eq("full_drop", req_dropped, 1);
    check_eq("full_inflight", inflight, 3);

    // retirement coincident with a launch
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_eq("coincident_inflight", inflight, 2);
    run(60);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check_eq("no_underflow", inflight, 0);

    // skip dead shooters from last_id=0 to id 7
    do_reset();
    alive = '1;
    step(1'b1, 1'b0); run(60);
    alive = 8'b1000_0001;
    t = cyc;
    step(1'b1, 1'b0);
    run(7);
    check_eq("skip_fire", fire, 1);
    check_eq("skip_id", fire_id, 7);
    run(60);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // nobody alive: request dropped after a full scan
    alive = '0;
    step(1'b1, 1'b0);
    run(8);
    check_eq("dead_drop", req_dropped, 1);
    check_eq("dead_inflight", inflight, 0);
    run(3);

    // reset during cooldown, then immediate request
    do_reset();
    alive = '1;
    step(1'b1, 1'b0);
    run(5);
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("post_rst_fire", fire, 1);
    check_eq("post_rst_id", fire_id, 0);
    step(1'b0, 1'b0);
    check_eq("post_rst_inflight", inflight, 1);
`ifdef SHOT_BURST_EN
    run(4);
    check_eq("burst_fire", fire, 1);
    step(1'b0, 1'b0);
    check_eq("burst_inflight", inflight, 2);
`endif
    run(60);

    // reset during a long scan abandons the shot
    do_reset();
    alive = 8'b1000_0000;
    step(1'b1, 1'b0);
    run(3);
    do_reset();
    run(20);
    check_eq("abandon_busy", busy, 0);
    check_eq("abandon_inflight", inflight, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (cyc >= m_busy_end && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       alive = '0;
          1:       alive = N'(1) << $urandom_range(0, N - 1);
          default: alive = N'($urandom);
        endcase
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
